// File: rtl/key_filter_pkg.sv
// Shared encoding and timing constants for the key_filter debounce front end.
// Default thresholds are derived from the 50 MHz board clock.
package key_filter_pkg;

    localparam int CLK_HZ      = 32'd50_000_000;
    localparam int DEBOUNCE_MS = 32'd20;
    localparam int LONG_MS     = 32'd1000;

    localparam int DEF_CNT_MAX  = (CLK_HZ / 32'd1000) * DEBOUNCE_MS - 32'd1;
    localparam int DEF_LONG_MAX = (CLK_HZ / 32'd1000) * LONG_MS - 32'd1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } key_st_e;

endpackage

// File: rtl/key_filter_ch.sv
// Single-key channel: 2-FF synchroniser, debounce FSM, debounce and long-press counters.
// All outputs are registered; key_in only reaches them through the synchroniser.
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter int CNT_MAX  = DEF_CNT_MAX,
    parameter int LONG_MAX = DEF_LONG_MAX
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_long,
    output logic key_state
);

    localparam int CW = $clog2(LONG_MAX + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          k_s;
    key_st_e       state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [CW-1:0] long_cnt_q,  long_cnt_d;
    logic          long_done_q, long_done_d;
    logic          flag_q,      flag_d;
    logic          long_q,      long_d;
    logic          kstate_q,    kstate_d;
    logic [CW-1:0] cnt_inc_s;

    // Two-stage synchroniser; released level is 1.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign k_s = sync2_q;
    // The sample that enters a debounce state is the first of CNT_MAX+1,
    // so the state changes when the incremented count reaches CNT_MAX.
    assign cnt_inc_s = cnt_q + {{(CW-1){1'b0}}, 1'b1};

    // FSM and counter state registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            long_cnt_q  <= {CW{1'b0}};
            long_done_q <= 1'b0;
            flag_q      <= 1'b0;
            long_q      <= 1'b0;
            kstate_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            flag_q      <= flag_d;
            long_q      <= long_d;
            kstate_q    <= kstate_d;
        end
    end

    // Next-state, counter and pulse logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = {CW{1'b0}};
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        flag_d      = 1'b0;
        long_d      = 1'b0;
        kstate_d    = kstate_q;
        case (state_q)
            IDLE: begin
                kstate_d = 1'b0;
                if (!k_s) begin
                    state_d = PRESS_DB;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS_DB: begin
                if (k_s) begin
                    state_d = IDLE;
                end else if (cnt_inc_s == CW'(CNT_MAX)) begin
                    state_d     = PRESSED;
                    flag_d      = 1'b1;
                    kstate_d    = 1'b1;
                    long_cnt_d  = {CW{1'b0}};
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            PRESSED: begin
                // Saturate at LONG_MAX; long_done blocks a repeat pulse.
                if (long_cnt_q != CW'(LONG_MAX)) begin
                    long_cnt_d = long_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else if (!long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end else begin
                    long_cnt_d = long_cnt_q;
                end
                if (k_s) begin
                    state_d = RELEASE_DB;
                end else begin
                    state_d = PRESSED;
                end
            end
            RELEASE_DB: begin
                if (!k_s) begin
                    state_d = PRESSED;
                end else if (cnt_inc_s == CW'(CNT_MAX)) begin
                    state_d     = IDLE;
                    kstate_d    = 1'b0;
                    long_cnt_d  = {CW{1'b0}};
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d  = IDLE;
                kstate_d = 1'b0;
            end
        endcase
    end

    assign key_flag  = flag_q;
    assign key_long  = long_q;
    assign key_state = kstate_q;

endmodule

// File: rtl/key_filter.sv
// Debounced push-button front end: one independent key_filter_ch per key.
// Produces press pulses, long-press pulses and debounced levels.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int KEY_W    = 32'd2,
    parameter int CNT_MAX  = DEF_CNT_MAX,
    parameter int LONG_MAX = DEF_LONG_MAX
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_flag,
    output logic [KEY_W-1:0] key_long,
    output logic [KEY_W-1:0] key_state
);

    for (genvar g = 0; g < KEY_W; g++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX  (CNT_MAX),
            .LONG_MAX (LONG_MAX)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key_in    (key_in[g]),
            .key_flag  (key_flag[g]),
            .key_long  (key_long[g]),
            .key_state (key_state[g])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with KEY_W=2, CNT_MAX=9, LONG_MAX=49, 20 ns clock.
module tb_key_filter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [1:0] key_in;
    logic [1:0] key_flag;
    logic [1:0] key_long;
    logic [1:0] key_state;

    int total = 0;
    int bad   = 0;
    int fc0, fc1, lc0, lc1;
    logic sh0;

    key_filter #(
        .KEY_W    (2),
        .CNT_MAX  (9),
        .LONG_MAX (49)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_long  (key_long),
        .key_state (key_state)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    // Advance n edges, sampling 1 ns after each and accumulating pulse counts.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            fc0 += int'(key_flag[0]);
            fc1 += int'(key_flag[1]);
            lc0 += int'(key_long[0]);
            lc1 += int'(key_long[1]);
            sh0 = sh0 | key_state[0];
        end
    endtask

    task automatic clr();
        fc0 = 0; fc1 = 0; lc0 = 0; lc1 = 0; sh0 = 1'b0;
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_in    = 2'b11;
        clr();
        tick(3);
        chk2("rst_flag",  key_flag,  2'b00);
        chk2("rst_long",  key_long,  2'b00);
        chk2("rst_state", key_state, 2'b00);
        sys_rst_n = 1'b1;
        tick(3);

        // Clean press on key 0, held 200 cycles
        clr();
        key_in = 2'b10;
        tick(11);
        chk2("press_e11_flag",  key_flag,  2'b00);
        chk2("press_e11_state", key_state, 2'b00);
        tick(1);
        chk2("press_e12_flag",  key_flag,  2'b01);
        chk2("press_e12_state", key_state, 2'b01);
        tick(1);
        chk2("press_e13_flag",  key_flag,  2'b00);
        tick(48);
        chk2("long_e61", key_long, 2'b00);
        tick(1);
        chk2("long_e62", key_long, 2'b01);
        tick(1);
        chk2("long_e63", key_long, 2'b00);
        tick(137);
        chkn("press_flag_cnt", fc0, 1);
        chkn("press_long_cnt", lc0, 1);

        // Release bounce: high 5, low 4, then high and stable
        key_in = 2'b11;
        tick(5);
        key_in = 2'b10;
        tick(4);
        chk2("relb_mid_state", key_state, 2'b01);
        key_in = 2'b11;
        tick(11);
        chk2("relb_e11_state", key_state, 2'b01);
        tick(1);
        chk2("relb_e12_state", key_state, 2'b00);
        tick(5);
        chkn("relb_flag_cnt", fc0, 1);
        chkn("relb_long_cnt", lc0, 1);

        // Bounce: toggle every 3 cycles for 30 cycles
        clr();
        for (int i = 0; i < 10; i++) begin
            key_in[0] = i[0];
            tick(3);
        end
        key_in = 2'b11;
        tick(20);
        chkn("bounce_flag_cnt", fc0, 0);
        chkn("bounce_long_cnt", lc0, 0);
        chkn("bounce_state_hi", int'(sh0), 0);

        // Both keys pressed on the same edge
        clr();
        key_in = 2'b00;
        tick(11);
        chk2("both_e11_flag", key_flag, 2'b00);
        tick(1);
        chk2("both_e12_flag",  key_flag,  2'b11);
        chk2("both_e12_state", key_state, 2'b11);
        tick(1);
        chk2("both_e13_flag", key_flag, 2'b00);
        key_in = 2'b11;
        tick(15);
        chk2("both_rel_state", key_state, 2'b00);
        chkn("both_flag_cnt0", fc0, 1);
        chkn("both_flag_cnt1", fc1, 1);

        // Reset mid-press on key 1
        clr();
        key_in = 2'b01;
        tick(8);
        sys_rst_n = 1'b0;
        #1;
        chk2("mrst_flag",  key_flag,  2'b00);
        chk2("mrst_state", key_state, 2'b00);
        chk2("mrst_long",  key_long,  2'b00);
        #99;
        chk2("mrst_end_state", key_state, 2'b00);
        sys_rst_n = 1'b1;
        tick(11);
        chk2("mrst_e11_flag", key_flag, 2'b00);
        tick(1);
        chk2("mrst_e12_flag",  key_flag,  2'b10);
        chk2("mrst_e12_state", key_state, 2'b10);
        key_in = 2'b11;
        tick(15);
        chk2("mrst_rel_state", key_state, 2'b00);
        chkn("mrst_flag_cnt1", fc1, 1);

        // Short press on key 0, 20 cycles
        clr();
        key_in = 2'b10;
        tick(12);
        chk2("short_e12_flag", key_flag, 2'b01);
        tick(8);
        key_in = 2'b11;
        tick(60);
        chkn("short_flag_cnt", fc0, 1);
        chkn("short_long_cnt", lc0, 0);
        chk2("short_state", key_state, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
